mips_memory_arbiter: RTL and testbench

- Shares the single-ported mips_memory between two requesters: port 0 (instruction fetch) and port 1 (load/store).
- Arbitrates round-robin and sequences exactly one memory access at a time.
- Per port: request/acknowledge handshake; read data is returned registered.
- Sits between the datapath and mips_memory, and drives mips_memory's address, write-data, write-enable and read-enable signals.

---
 rtl/mips_memory_arbiter_pkg.sv | 16 +
 rtl/mips_memory_arbiter_if.sv | 46 ++++
 rtl/mips_memory_arbiter_rr_arbiter2.sv | 23 ++
 rtl/mips_memory_arbiter.sv | 123 ++++++++++++
 tb/tb_mips_memory_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_memory_arbiter_pkg.sv
// Shared types and constants for the mips_memory arbiter.
// Holds FSM state encoding, port indices and counter width.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic PORT_IFETCH = 1'b0;
   localparam logic PORT_LSU    = 1'b1;

   localparam int CNT_W = 4;

endpackage

// File: rtl/mips_memory_arbiter_if.sv
// Bundle of both requester handshakes and the memory-side bus.
// slave: arbiter view; master: datapath/memory view.
interface mips_memory_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic              req0;
   logic              we0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              ack0;
   logic [DATA_W-1:0] rdata0;

   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              ack1;
   logic [DATA_W-1:0] rdata1;

   logic [ADDR_W-1:0] write_data_address;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] read_mem;
   logic              signal_mem_write;
   logic              signal_mem_read;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  read_mem,
      output ack0, rdata0, ack1, rdata1,
      output write_data_address, write_data,
      output signal_mem_write, signal_mem_read
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output read_mem,
      input  ack0, rdata0, ack1, rdata1,
      input  write_data_address, write_data,
      input  signal_mem_write, signal_mem_read
   );

endinterface

// File: rtl/mips_memory_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports: i_req0/i_req1, i_last_grant -> o_grant_valid, o_grant_idx.
module rr_arbiter2
   import mips_mem_pkg::*;
(
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_last_grant,
   output logic o_grant_valid,
   output logic o_grant_idx
);

   always_comb begin
      o_grant_valid = i_req0 | i_req1;
      o_grant_idx   = PORT_IFETCH;
      unique case (1'b1)
         (i_req0 && i_req1):  o_grant_idx = ~i_last_grant;
         (i_req1 && !i_req0): o_grant_idx = PORT_LSU;
         default:             o_grant_idx = PORT_IFETCH;
      endcase
   end

endmodule

// File: rtl/mips_memory_arbiter.sv
// Shares single-ported mips_memory between ifetch (0) and LSU (1).
// Ports: clk, reset (async high), bus (slave view of the bundle).
module mips_memory_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   mips_memory_arbiter_if.slave  bus
);

   if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_lat_chk
      $error("MEM_LATENCY must be within 1..15");
   end

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

   state_t            r_state;
   logic              r_last_grant;
   logic              r_grant;
   logic              r_we;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ack0;
   logic              r_ack1;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_mem_wr;
   logic              r_mem_rd;

   logic              w_gnt_valid;
   logic              w_gnt_idx;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;

   rr_arbiter2 u_arb (
      .i_req0        (bus.req0),
      .i_req1        (bus.req1),
      .i_last_grant  (r_last_grant),
      .o_grant_valid (w_gnt_valid),
      .o_grant_idx   (w_gnt_idx)
   );

   assign w_sel_we    = w_gnt_idx ? bus.we1    : bus.we0;
   assign w_sel_addr  = w_gnt_idx ? bus.addr1  : bus.addr0;
   assign w_sel_wdata = w_gnt_idx ? bus.wdata1 : bus.wdata0;

   // The memory address/data registers double as the request latch,
   // so they keep their last value while idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_last_grant <= PORT_LSU;
         r_grant      <= PORT_IFETCH;
         r_we         <= 1'b0;
         r_cnt        <= '0;
         r_ack0       <= 1'b0;
         r_ack1       <= 1'b0;
         r_rdata0     <= '0;
         r_rdata1     <= '0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_mem_wr     <= 1'b0;
         r_mem_rd     <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_ack0   <= 1'b0;
               r_ack1   <= 1'b0;
               r_mem_wr <= 1'b0;
               r_mem_rd <= 1'b0;
               if (w_gnt_valid) begin
                  r_grant      <= w_gnt_idx;
                  r_last_grant <= w_gnt_idx;
                  r_we         <= w_sel_we;
                  r_mem_addr   <= w_sel_addr;
                  r_mem_wdata  <= w_sel_wdata;
                  r_mem_wr     <= w_sel_we;
                  r_mem_rd     <= ~w_sel_we;
                  r_cnt        <= CNT_LOAD;
                  r_state      <= ACCESS;
               end
            end
            ACCESS: begin
               if (r_cnt == '0) begin
                  r_mem_wr <= 1'b0;
                  r_mem_rd <= 1'b0;
                  if (!r_we) begin
                     if (r_grant == PORT_LSU) r_rdata1 <= bus.read_mem;
                     else                     r_rdata0 <= bus.read_mem;
                  end
                  r_ack0  <= (r_grant == PORT_IFETCH);
                  r_ack1  <= (r_grant == PORT_LSU);
                  r_state <= RESP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            RESP: begin
               r_ack0  <= 1'b0;
               r_ack1  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.ack0               = r_ack0;
   assign bus.ack1               = r_ack1;
   assign bus.rdata0             = r_rdata0;
   assign bus.rdata1             = r_rdata1;
   assign bus.write_data_address = r_mem_addr;
   assign bus.write_data         = r_mem_wdata;
   assign bus.signal_mem_write   = r_mem_wr;
   assign bus.signal_mem_read    = r_mem_rd;

endmodule

// File: tb/tb_mips_memory_arbiter.sv
// Directed bench for mips_memory_arbiter (latency 1 and 3 instances).
// Each task drives one scenario and compares against hand values.
module tb_mips_memory_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mips_memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
   mips_memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

   mips_memory_arbiter #(.MEM_LATENCY(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   mips_memory_arbiter #(.MEM_LATENCY(3)) dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3)
   );

   logic [31:0] mem1 [0:15];
   logic [31:0] mem3 [0:15];

   assign bus1.read_mem = mem1[bus1.write_data_address[3:0]];
   assign bus3.read_mem = mem3[bus3.write_data_address[3:0]];

   always @(posedge clk) begin
      if (bus1.signal_mem_write)
         mem1[bus1.write_data_address[3:0]] <= bus1.write_data;
      if (bus3.signal_mem_write)
         mem3[bus3.write_data_address[3:0]] <= bus3.write_data;
   end

   logic [3:0] st1, st3;
   assign st1 = {bus1.ack0, bus1.ack1,
                 bus1.signal_mem_read, bus1.signal_mem_write};
   assign st3 = {bus3.ack0, bus3.ack1,
                 bus3.signal_mem_read, bus3.signal_mem_write};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      bus1.req0 = 0; bus1.we0 = 0; bus1.addr0 = '0; bus1.wdata0 = '0;
      bus1.req1 = 0; bus1.we1 = 0; bus1.addr1 = '0; bus1.wdata1 = '0;
      bus3.req0 = 0; bus3.we0 = 0; bus3.addr0 = '0; bus3.wdata0 = '0;
      bus3.req1 = 0; bus3.we1 = 0; bus3.addr1 = '0; bus3.wdata1 = '0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick;
      tick;
      n_vec++;
      if (st1 !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_ctl1: got %b want 0000", st1);
      end
      n_vec++;
      if (st3 !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_ctl3: got %b want 0000", st3);
      end
      n_vec++;
      if ({bus1.rdata0, bus1.rdata1} !== 64'h0) begin
         n_err++;
         $display("FAIL reset_rdata: got %h %h want 0 0",
                  bus1.rdata0, bus1.rdata1);
      end
      n_vec++;
      if ({bus1.write_data_address, bus1.write_data} !== 64'h0) begin
         n_err++;
         $display("FAIL reset_membus: got %h %h want 0 0",
                  bus1.write_data_address, bus1.write_data);
      end
      reset = 1'b0;
      tick;
   endtask

   task automatic test_read_p0;
      bus1.req0 = 1; bus1.we0 = 0; bus1.addr0 = 32'd1;
      tick;
      n_vec++;
      if (st1 !== 4'b0010 || bus1.write_data_address !== 32'd1) begin
         n_err++;
         $display("FAIL rd0_access: got %b a=%h want 0010 a=1",
                  st1, bus1.write_data_address);
      end
      tick;
      n_vec++;
      if (st1 !== 4'b1000 || bus1.rdata0 !== 32'h5) begin
         n_err++;
         $display("FAIL rd0_ack: got %b d=%h want 1000 d=5",
                  st1, bus1.rdata0);
      end
      bus1.req0 = 0;
      tick;
      n_vec++;
      if (st1 !== 4'b0000 || bus1.rdata0 !== 32'h5) begin
         n_err++;
         $display("FAIL rd0_idle: got %b d=%h want 0000 d=5",
                  st1, bus1.rdata0);
      end
   endtask

   task automatic test_write_read_p1;
      bus1.req1 = 1; bus1.we1 = 1; bus1.addr1 = 32'd0;
      bus1.wdata1 = 32'hFFFF_FFFF;
      tick;
      n_vec++;
      if (st1 !== 4'b0001 || bus1.write_data !== 32'hFFFF_FFFF ||
          bus1.write_data_address !== 32'd0) begin
         n_err++;
         $display("FAIL wr1_access: got %b a=%h d=%h want 0001 0 ffffffff",
                  st1, bus1.write_data_address, bus1.write_data);
      end
      tick;
      n_vec++;
      if (st1 !== 4'b0100 || bus1.rdata1 !== 32'h0) begin
         n_err++;
         $display("FAIL wr1_ack: got %b d=%h want 0100 d=0",
                  st1, bus1.rdata1);
      end
      bus1.req1 = 0;
      tick;
      n_vec++;
      if (st1 !== 4'b0000) begin
         n_err++;
         $display("FAIL wr1_idle: got %b want 0000", st1);
      end
      bus1.we1 = 0; bus1.req1 = 1;
      tick;
      n_vec++;
      if (st1 !== 4'b0010) begin
         n_err++;
         $display("FAIL rd1_access: got %b want 0010", st1);
      end
      tick;
      n_vec++;
      if (st1 !== 4'b0100 || bus1.rdata1 !== 32'hFFFF_FFFF ||
          bus1.rdata0 !== 32'h5) begin
         n_err++;
         $display("FAIL rd1_ack: got %b d1=%h d0=%h want 0100 ffffffff 5",
                  st1, bus1.rdata1, bus1.rdata0);
      end
      bus1.req1 = 0;
      tick;
   endtask

   task automatic test_contention;
      logic [3:0] exp;
      bus1.req0 = 1; bus1.we0 = 0; bus1.addr0 = 32'd1;
      bus1.req1 = 1; bus1.we1 = 0; bus1.addr1 = 32'd0;
      for (int k = 0; k < 12; k++) begin
         tick;
         exp = {(k == 1 || k == 7), (k == 4 || k == 10),
                ((k % 3) == 0 && k <= 9), 1'b0};
         n_vec++;
         if (st1 !== exp) begin
            n_err++;
            $display("FAIL contend_k%0d: got %b want %b", k, st1, exp);
         end
         if (k == 7) begin
            n_vec++;
            if (bus1.rdata0 !== 32'h5) begin
               n_err++;
               $display("FAIL contend_d0: got %h want 5", bus1.rdata0);
            end
         end
         if (k == 10) begin
            n_vec++;
            if (bus1.rdata1 !== 32'hFFFF_FFFF) begin
               n_err++;
               $display("FAIL contend_d1: got %h want ffffffff",
                        bus1.rdata1);
            end
            bus1.req0 = 0;
            bus1.req1 = 0;
         end
      end
   endtask

   task automatic test_latency3;
      logic [3:0] exp;
      bus3.req0 = 1; bus3.we0 = 0; bus3.addr0 = 32'd1;
      for (int k = 0; k < 5; k++) begin
         tick;
         exp = (k < 3) ? 4'b0010 : (k == 3) ? 4'b1000 : 4'b0000;
         n_vec++;
         if (st3 !== exp) begin
            n_err++;
            $display("FAIL lat3_k%0d: got %b want %b", k, st3, exp);
         end
         if (k == 3) begin
            n_vec++;
            if (bus3.rdata0 !== 32'h5) begin
               n_err++;
               $display("FAIL lat3_data: got %h want 5", bus3.rdata0);
            end
            bus3.req0 = 0;
         end
      end
   endtask

   task automatic test_reset_mid;
      bus1.req0 = 1; bus1.we0 = 0; bus1.addr0 = 32'd1;
      bus1.req1 = 1; bus1.we1 = 0; bus1.addr1 = 32'd0;
      tick;
      n_vec++;
      if (st1 !== 4'b0010 || bus1.write_data_address !== 32'd1) begin
         n_err++;
         $display("FAIL rstmid_pre: got %b a=%h want 0010 a=1",
                  st1, bus1.write_data_address);
      end
      #1 reset = 1'b1;
      #1;
      n_vec++;
      if (st1 !== 4'b0000 || bus1.write_data_address !== 32'd0 ||
          bus1.rdata0 !== 32'd0 || bus1.rdata1 !== 32'd0) begin
         n_err++;
         $display("FAIL rstmid_async: got %b a=%h d0=%h d1=%h want zeros",
                  st1, bus1.write_data_address, bus1.rdata0, bus1.rdata1);
      end
      tick;
      n_vec++;
      if (st1 !== 4'b0000) begin
         n_err++;
         $display("FAIL rstmid_noack: got %b want 0000", st1);
      end
      reset = 1'b0;
      tick;
      n_vec++;
      if (st1 !== 4'b0010 || bus1.write_data_address !== 32'd1) begin
         n_err++;
         $display("FAIL rstmid_first: got %b a=%h want 0010 a=1",
                  st1, bus1.write_data_address);
      end
      tick;
      n_vec++;
      if (st1 !== 4'b1000 || bus1.rdata0 !== 32'h5) begin
         n_err++;
         $display("FAIL rstmid_ack0: got %b d=%h want 1000 d=5",
                  st1, bus1.rdata0);
      end
      bus1.req0 = 0;
      tick;
      tick;
      n_vec++;
      if (st1 !== 4'b0010 || bus1.write_data_address !== 32'd0) begin
         n_err++;
         $display("FAIL rstmid_second: got %b a=%h want 0010 a=0",
                  st1, bus1.write_data_address);
      end
      tick;
      n_vec++;
      if (st1 !== 4'b0100 || bus1.rdata1 !== 32'hFFFF_FFFF) begin
         n_err++;
         $display("FAIL rstmid_ack1: got %b d=%h want 0100 ffffffff",
                  st1, bus1.rdata1);
      end
      bus1.req1 = 0;
      tick;
   endtask

   task automatic test_drop_mid;
      bus1.req0 = 1; bus1.we0 = 0; bus1.addr0 = 32'd2;
      tick;
      n_vec++;
      if (st1 !== 4'b0010 || bus1.write_data_address !== 32'd2) begin
         n_err++;
         $display("FAIL drop_access: got %b a=%h want 0010 a=2",
                  st1, bus1.write_data_address);
      end
      bus1.req0 = 0;
      tick;
      n_vec++;
      if (st1 !== 4'b1000 || bus1.rdata0 !== 32'h1234_5678) begin
         n_err++;
         $display("FAIL drop_ack: got %b d=%h want 1000 12345678",
                  st1, bus1.rdata0);
      end
      for (int k = 0; k < 3; k++) begin
         tick;
         n_vec++;
         if (st1 !== 4'b0000) begin
            n_err++;
            $display("FAIL drop_quiet_k%0d: got %b want 0000", k, st1);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem1[i] <= 32'h0;
         mem3[i] <= 32'h0;
      end
      mem1[1] <= 32'h0000_0005;
      mem1[2] <= 32'h1234_5678;
      mem3[1] <= 32'h0000_0005;
      clear_inputs;
      test_reset;
      test_read_p0;
      test_write_read_p1;
      test_contention;
      test_latency3;
      test_reset_mid;
      test_drop_mid;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
